tsc_multicycle_core: RTL and testbench
======================================

// Module: tsc_multicycle_core
// PURPOSE
//  Parametrised multi-cycle TSC CPU core: FETCH/DECODE/EXEC/WB state machine.
//  Instructions come from an external instruction memory over a req/ack handshake instead of an internal ROM.
//  Adds branches, HLT, wait-state tolerance and an instruction counter.
//  Sits under the board top, driving output_logic via output_port / PC_below8bit.
// PARAMETERS
//  WORD_SIZE   16  register/ALU data width (>=16); instruction word is always 16 bits
//  ADDR_WIDTH  16  PC / instruction address width (>=12)
//  PC_RESET    0   PC value loaded on reset
// PORTS
//  clk                input   1           clock; all state changes on rising edge
//  reset_cpu_n        input   1           synchronous reset, active-low
//  cpu_enable         input   1           1 = may start fetching a new instruction
//  wwd_enable         input   1           1 = WWD drives output_port; 0 = register_selection view
//  register_selection input   2           register shown on output_port when wwd_enable=0
//  i_req              output  1           instruction fetch request; = (state==FETCH)
//  i_addr             output  ADDR_WIDTH  fetch address; = PC
//  i_ack              input   1           fetch done; i_data valid this cycle
//  i_data             input   16          instruction word
//  output_port        output  WORD_SIZE   registered display value
//  output_valid       output  1           1-cycle pulse when a WWD updates output_port
//  PC_below8bit       output  8           PC[7:0]
//  num_inst           output  16          retired-instruction count (simulation)
//  halted             output  1           1 while in HALT
// BEHAVIOUR
//  - Reset (reset_cpu_n=0 at edge): state=IDLE, PC=PC_RESET, R0..R3=0,
//    output_port=0, output_valid=0, num_inst=0, halted=0. Overrides everything, incl. mid-fetch.
//  - States:
//    - IDLE -> FETCH when cpu_enable=1, else stay.
//    - FETCH: i_req=1. On i_ack=1, latch i_data into IR -> DECODE; else stay (any wait count; ack in same cycle allowed).
//    - DECODE: read rs/rt, form imm -> EXEC.
//    - EXEC: ALU / branch compare -> WB, except HLT -> HALT.
//    - WB: register write, PC update, num_inst++ (wraps at 16 bits) -> FETCH if cpu_enable=1 else IDLE.
//    - HALT: terminal; only reset exits. num_inst counts HLT once.
//  - Zero-wait latency: 4 cycles/instruction. cpu_enable only gates instruction starts; a started instruction always completes.
//  - ISA (IR[15:12]=op; rs=[11:10], rt=[9:8], rd=[7:6], imm=[7:0], target=[11:0]):
//    - op 0 BNE / op 1 BEQ: compare rs vs rt; taken -> PC+1+sext(imm), else PC+1.
//    - op 4 ADI: rt = rs + sext(imm).
//    - op 6 LHI: rt = zext(imm)<<8.
//    - op 9 JMP: PC = {PC[ADDR_WIDTH-1:12], target}.
//    - op 15 func 0 ADD: rd = rs + rt. func 28 WWD: shows rs. func 29 HLT.
//    - Anything else: NOP, PC+1, counted.
//  - Arithmetic is WORD_SIZE-bit, modulo 2^WORD_SIZE, no flags. PC adds wrap modulo 2^ADDR_WIDTH.
//  - Non-jump PC update is PC+1 in WB. Register write and PC update happen on the same WB edge.
//  - Same-register read-after-write is safe: the read in DECODE follows the previous WB.
//  - output_port:
//    - wwd_enable=1: loaded with R[rs] in WB of WWD, with output_valid=1 for that cycle; otherwise held.
//    - wwd_enable=0: loaded every cycle with R[register_selection] (value after any same-edge write is not required; previous value is acceptable). output_valid=0.
// TESTING
//  1. Reset held 2 cycles, then cpu_enable=1, zero-wait memory -> i_addr=0, i_req=1 in first post-reset FETCH; all outputs 0.
//  2. Program LHI $0,0; LHI $1,1; ADI $2,$0,4; ADI $3,$1,-4; ADD $3,$1,$2; WWD $3; HLT:
//     - WWD pulses output_valid with output_port=16'h0104.
//     - halted=1 and num_inst=7 after 28 cycles.
//  3. BEQ $0,$0,+2 at PC 5 -> next i_addr=8. BNE $0,$0,+2 -> next i_addr=6. JMP 21 -> i_addr=21.
//  4. i_ack delayed 3 cycles per fetch -> i_req/i_addr held stable, identical register results, 7 cycles per instruction.
//  5. cpu_enable dropped during EXEC of ADD -> ADD retires, core parks in IDLE with PC+1, resumes on re-enable.
//  6. wwd_enable=0, register_selection=2 after step 2 -> output_port=16'h0004 next cycle. Reset asserted mid-FETCH -> IDLE, PC=0.

Source files
------------

// File: rtl/tsc_multicycle_core.sv
// Multi-cycle TSC core: FETCH/DECODE/EXEC/WB sequencer with an external
// req/ack instruction port, branches, HLT and a retired-instruction counter.
module tsc_multicycle_core #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned PC_RESET   = 0
) (
    input  logic                  clk,
    input  logic                  reset_cpu_n,
    input  logic                  cpu_enable,
    input  logic                  wwd_enable,
    input  logic [1:0]            register_selection,
    output logic                  i_req,
    output logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_ack,
    input  logic [15:0]           i_data,
    output logic [WORD_SIZE-1:0]  output_port,
    output logic                  output_valid,
    output logic [7:0]            PC_below8bit,
    output logic [15:0]           num_inst,
    output logic                  halted
);

    localparam int unsigned NUM_REGS = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_BNE   = 4'd0;
    localparam logic [3:0] OP_BEQ   = 4'd1;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_ADD = 6'd0;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    // JMP replaces only the low 12 PC bits; the page bits above are kept.
    localparam logic [ADDR_WIDTH-1:0] JMP_MASK = ADDR_WIDTH'(12'hFFF);

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] pc;
    logic [15:0]           ir;
    logic [WORD_SIZE-1:0]  regs [NUM_REGS];
    logic [WORD_SIZE-1:0]  a_q;
    logic [WORD_SIZE-1:0]  b_q;
    logic [WORD_SIZE-1:0]  alu_q;
    logic                  wr_en_q;
    logic [1:0]            wr_addr_q;
    logic [ADDR_WIDTH-1:0] pc_nxt_q;
    logic                  wwd_q;

    // Instruction field decode from the latched IR
    logic [3:0]            op;
    logic [1:0]            rs;
    logic [1:0]            rt;
    logic [1:0]            rd;
    logic [7:0]            imm8;
    logic [5:0]            func;
    logic [11:0]           target;
    logic [WORD_SIZE-1:0]  imm_word;
    logic [ADDR_WIDTH-1:0] imm_addr;
    logic                  is_hlt;

    assign op       = ir[15:12];
    assign rs       = ir[11:10];
    assign rt       = ir[9:8];
    assign rd       = ir[7:6];
    assign imm8     = ir[7:0];
    assign func     = ir[5:0];
    assign target   = ir[11:0];
    assign imm_word = {{(WORD_SIZE-8){imm8[7]}}, imm8};
    assign imm_addr = {{(ADDR_WIDTH-8){imm8[7]}}, imm8};
    assign is_hlt   = (op == OP_RTYPE) && (func == FN_HLT);

    assign i_addr       = pc;
    assign PC_below8bit = pc[7:0];

    // Execute-stage results, captured at the end of EXEC
    logic [WORD_SIZE-1:0]  exe_alu;
    logic                  exe_wr_en;
    logic [1:0]            exe_wr_addr;
    logic [ADDR_WIDTH-1:0] exe_pc;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic                  exe_wwd;

    assign pc_inc = pc + ADDR_WIDTH'(1);

    always_comb begin
        exe_alu     = '0;
        exe_wr_en   = 1'b0;
        exe_wr_addr = rt;
        exe_pc      = pc_inc;
        exe_wwd     = 1'b0;
        case (op)
            OP_BNE: if (a_q != b_q) exe_pc = pc_inc + imm_addr;
            OP_BEQ: if (a_q == b_q) exe_pc = pc_inc + imm_addr;
            OP_ADI: begin
                exe_wr_en = 1'b1;
                exe_alu   = a_q + imm_word;
            end
            OP_LHI: begin
                exe_wr_en = 1'b1;
                exe_alu   = WORD_SIZE'({imm8, 8'h00});
            end
            OP_JMP: exe_pc = (pc & ~JMP_MASK) | ADDR_WIDTH'(target);
            OP_RTYPE: begin
                case (func)
                    FN_ADD: begin
                        exe_wr_en   = 1'b1;
                        exe_wr_addr = rd;
                        exe_alu     = a_q + b_q;
                    end
                    FN_WWD:  exe_wwd = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_cpu_n) state <= S_IDLE;
        else              state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (cpu_enable) state_nxt = S_FETCH;
            S_FETCH:  if (i_ack) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   state_nxt = is_hlt ? S_HALT : S_WB;
            S_WB:     state_nxt = cpu_enable ? S_FETCH : S_IDLE;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Status outputs registered from the next state so they track the FSM exactly
    always_ff @(posedge clk) begin
        if (!reset_cpu_n) begin
            i_req  <= 1'b0;
            halted <= 1'b0;
        end else begin
            i_req  <= (state_nxt == S_FETCH);
            halted <= (state_nxt == S_HALT);
        end
    end

    // Datapath: IR latch, operand read, execute capture, write-back
    always_ff @(posedge clk) begin
        if (!reset_cpu_n) begin
            pc        <= ADDR_WIDTH'(PC_RESET);
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            pc_nxt_q  <= '0;
            wwd_q     <= 1'b0;
            num_inst  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (i_ack) ir <= i_data;
                S_DECODE: begin
                    a_q <= regs[rs];
                    b_q <= regs[rt];
                end
                S_EXEC: begin
                    alu_q     <= exe_alu;
                    wr_en_q   <= exe_wr_en;
                    wr_addr_q <= exe_wr_addr;
                    pc_nxt_q  <= exe_pc;
                    wwd_q     <= exe_wwd;
                    if (is_hlt) num_inst <= num_inst + 16'd1;
                end
                S_WB: begin
                    if (wr_en_q) regs[wr_addr_q] <= alu_q;
                    pc       <= pc_nxt_q;
                    num_inst <= num_inst + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Display port: WWD capture or a live register view
    always_ff @(posedge clk) begin
        if (!reset_cpu_n) begin
            output_port  <= '0;
            output_valid <= 1'b0;
        end else if (!wwd_enable) begin
            output_port  <= regs[register_selection];
            output_valid <= 1'b0;
        end else if ((state == S_WB) && wwd_q) begin
            output_port  <= a_q;
            output_valid <= 1'b1;
        end else begin
            output_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tsc_multicycle_core.sv
// Scoreboard bench for tsc_multicycle_core: directed programs, expected fetch
// addresses and WWD values queued up front, checked by negedge monitors.
module tb_tsc_multicycle_core;

    logic        clk = 1'b0;
    logic        reset_cpu_n;
    logic        cpu_enable;
    logic        wwd_enable;
    logic [1:0]  register_selection;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic [15:0] i_data;
    logic [15:0] output_port;
    logic        output_valid;
    logic [7:0]  PC_below8bit;
    logic [15:0] num_inst;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [256];
    int          wait_cycles = 0;
    int          wcnt = 0;
    logic [15:0] fetch_addr;
    logic [15:0] exp_fetch [$];
    logic [15:0] exp_wwd   [$];

    tsc_multicycle_core #(.WORD_SIZE(16), .ADDR_WIDTH(16), .PC_RESET(0)) dut (
        .clk                (clk),
        .reset_cpu_n        (reset_cpu_n),
        .cpu_enable         (cpu_enable),
        .wwd_enable         (wwd_enable),
        .register_selection (register_selection),
        .i_req              (i_req),
        .i_addr             (i_addr),
        .i_ack              (i_ack),
        .i_data             (i_data),
        .output_port        (output_port),
        .output_valid       (output_valid),
        .PC_below8bit       (PC_below8bit),
        .num_inst           (num_inst),
        .halted             (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Instruction memory with programmable wait states; also checks fetch addresses
    always @(negedge clk) begin
        if (i_req) begin
            if (wcnt == 0) begin
                fetch_addr = i_addr;
                if (exp_fetch.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fetch_unexpected: got addr %h expected none", i_addr);
                end else begin
                    check("fetch_addr", 32'(i_addr), 32'(exp_fetch.pop_front()));
                end
            end else begin
                check("fetch_addr_hold", 32'(i_addr), 32'(fetch_addr));
            end
            if (wcnt >= wait_cycles) begin
                i_ack  = 1'b1;
                i_data = mem[i_addr[7:0]];
            end else begin
                i_ack  = 1'b0;
                i_data = 16'hxxxx;
            end
            wcnt++;
        end else begin
            i_ack = 1'b0;
            wcnt  = 0;
        end
    end

    // WWD monitor
    always @(negedge clk) begin
        if (output_valid) begin
            if (exp_wwd.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wwd_unexpected: got %h expected no pulse", output_port);
            end else begin
                check("wwd_value", 32'(output_port), 32'(exp_wwd.pop_front()));
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h2000;
    endtask

    // LHI $0,0; LHI $1,1; ADI $2,$0,4; ADI $3,$1,-4; ADD $3,$1,$2; WWD $3; HLT
    task automatic load_prog1(input int nfetch, input bit with_wwd);
        clear_mem();
        mem[0] = 16'h6000; mem[1] = 16'h6101; mem[2] = 16'h4204; mem[3] = 16'h47FC;
        mem[4] = 16'hF6C0; mem[5] = 16'hFC1C; mem[6] = 16'hF01D;
        for (int i = 0; i < nfetch; i++) exp_fetch.push_back(16'(i));
        if (with_wwd) exp_wwd.push_back(16'h0104);
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk);
        reset_cpu_n = 1'b0;
        cpu_enable  = en;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_cpu_n = 1'b1;
    endtask

    task automatic run_to_halt(input int start, output int cyc);
        cyc = start;
        while (!halted && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!halted) begin
            checks++;
            failures++;
            $display("FAIL halt_timeout: got halted=0 after %0d cycles expected halted=1", cyc);
        end
    endtask

    task automatic view_reg(input logic [1:0] sel, input logic [15:0] exp, input string name);
        @(negedge clk);
        wwd_enable         = 1'b0;
        register_selection = sel;
        @(posedge clk);
        #1;
        check(name, 32'(output_port), 32'(exp));
        check("view_no_valid", 32'(output_valid), 32'd0);
        @(negedge clk);
        wwd_enable = 1'b1;
    endtask

    initial begin
        int cyc;
        int n;
        reset_cpu_n        = 1'b0;
        cpu_enable         = 1'b0;
        wwd_enable         = 1'b1;
        register_selection = 2'd0;
        i_ack              = 1'b0;
        i_data             = 16'h0000;

        // Reset, first fetch, straight-line program with zero-wait memory
        wait_cycles = 0;
        load_prog1(7, 1'b1);
        do_reset(1'b1);
        check("rst_i_req", 32'(i_req), 32'd0);
        check("rst_num_inst", 32'(num_inst), 32'd0);
        @(posedge clk);
        #1;
        check("first_i_req", 32'(i_req), 32'd1);
        check("first_i_addr", 32'(i_addr), 32'd0);
        check("first_out", 32'(output_port), 32'd0);
        check("first_valid", 32'(output_valid), 32'd0);
        check("first_halted", 32'(halted), 32'd0);
        check("first_num_inst", 32'(num_inst), 32'd0);
        run_to_halt(1, cyc);
        check("p1_cycles", 32'(cyc), 32'd28);
        check("p1_num_inst", 32'(num_inst), 32'd7);
        check("p1_pc_halt", 32'(PC_below8bit), 32'd6);
        view_reg(2'd2, 16'h0004, "p1_r2");
        view_reg(2'd1, 16'h0100, "p1_r1");
        view_reg(2'd3, 16'h0104, "p1_r3");

        // Same program with three wait states per fetch
        wait_cycles = 3;
        load_prog1(7, 1'b1);
        do_reset(1'b1);
        run_to_halt(0, cyc);
        check("ws_cycles", 32'(cyc), 32'd49);
        check("ws_num_inst", 32'(num_inst), 32'd7);
        view_reg(2'd3, 16'h0104, "ws_r3");
        view_reg(2'd0, 16'h0000, "ws_r0");

        // Branches and jump
        wait_cycles = 0;
        clear_mem();
        mem[5]  = 16'h1002;   // BEQ $0,$0,+2  -> 8
        mem[8]  = 16'h0002;   // BNE $0,$0,+2  -> 9
        mem[9]  = 16'h9015;   // JMP 21
        mem[21] = 16'h10FD;   // BEQ $0,$0,-3  -> 19
        mem[19] = 16'h4101;   // ADI $1,$0,1
        mem[20] = 16'h0403;   // BNE $1,$0,+3  -> 24
        mem[24] = 16'hF41C;   // WWD $1
        mem[25] = 16'hF01D;   // HLT
        foreach (exp_fetch[i]) n = i;
        exp_fetch.push_back(16'd0);  exp_fetch.push_back(16'd1);  exp_fetch.push_back(16'd2);
        exp_fetch.push_back(16'd3);  exp_fetch.push_back(16'd4);  exp_fetch.push_back(16'd5);
        exp_fetch.push_back(16'd8);  exp_fetch.push_back(16'd9);  exp_fetch.push_back(16'd21);
        exp_fetch.push_back(16'd19); exp_fetch.push_back(16'd20); exp_fetch.push_back(16'd24);
        exp_fetch.push_back(16'd25);
        exp_wwd.push_back(16'h0001);
        do_reset(1'b1);
        run_to_halt(0, cyc);
        check("br_cycles", 32'(cyc), 32'd52);
        check("br_num_inst", 32'(num_inst), 32'd13);

        // cpu_enable dropped during EXEC of ADD
        clear_mem();
        mem[0] = 16'h4105;   // ADI $1,$0,5
        mem[1] = 16'hF580;   // ADD $2,$1,$1
        mem[2] = 16'hF81C;   // WWD $2
        mem[3] = 16'hF01D;   // HLT
        for (int i = 0; i < 4; i++) exp_fetch.push_back(16'(i));
        exp_wwd.push_back(16'h000A);
        do_reset(1'b1);
        repeat (7) @(posedge clk);
        @(negedge clk);
        cpu_enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("park_i_req", 32'(i_req), 32'd0);
        check("park_pc", 32'(PC_below8bit), 32'd2);
        check("park_num_inst", 32'(num_inst), 32'd2);
        check("park_halted", 32'(halted), 32'd0);
        @(negedge clk);
        cpu_enable = 1'b1;
        run_to_halt(0, cyc);
        check("park_final_num_inst", 32'(num_inst), 32'd4);

        // Reset asserted in the middle of a stalled fetch
        wait_cycles = 3;
        load_prog1(3, 1'b0);
        do_reset(1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(i_req && i_addr == 16'd2) && n < 100);
        check("midfetch_reached", 32'(i_req && i_addr == 16'd2), 32'd1);
        reset_cpu_n = 1'b0;
        cpu_enable  = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_i_req", 32'(i_req), 32'd0);
        check("midrst_pc", 32'(i_addr), 32'd0);
        check("midrst_num_inst", 32'(num_inst), 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        check("midrst_out", 32'(output_port), 32'd0);
        @(negedge clk);
        reset_cpu_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_i_req", 32'(i_req), 32'd0);

        check("fetch_queue_drained", 32'(exp_fetch.size()), 32'd0);
        check("wwd_queue_drained", 32'(exp_wwd.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
